// File: rtl/corrector_secded_param.sv
// corrector_secded_param: two-stage pipelined SECDED (extended Hamming) decoder.
// It computes the syndrome and overall parity of a received codeword and
// corrects single errors unless detect-only mode is selected. It also keeps
// saturating error counters and a sticky double-error flag.
// Ports:
//   reloj, rst_n                  clock, async active-low reset
//   in_valid/in_ready/recibido    input handshake and raw codeword (N bits)
//   corregir_en                   1 = correct single errors, 0 = detect only
//   out_valid/out_ready           output handshake
//   palabra_corregida, corregido  corrected codeword and extracted data bits
//   sindrome, error_simple/doble  syndrome and error classification
//   clr_cnt, cnt_simple/doble     counter clear and error-event counters
//   led_doblerror                 sticky double-error flag
module corrector_secded_param #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned CNT_W  = 16,
    localparam int unsigned P = (DATA_W <= 4)  ? 3 :
                                (DATA_W <= 11) ? 4 :
                                (DATA_W <= 26) ? 5 : 6,
    localparam int unsigned N = DATA_W + P + 1
) (
    input  logic              reloj,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N-1:0]      recibido,
    input  logic              corregir_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N-1:0]      palabra_corregida,
    output logic [DATA_W-1:0] corregido,
    output logic [P-1:0]      sindrome,
    output logic              error_simple,
    output logic              error_doble,
    input  logic              clr_cnt,
    output logic [CNT_W-1:0]  cnt_simple,
    output logic [CNT_W-1:0]  cnt_doble,
    output logic              led_doblerror
);

    localparam logic [P-1:0] S_MAX = P'(N - 1);

    // Bit index in the codeword of data bit j (j-th non-power-of-two position).
    function automatic int unsigned data_idx(input int unsigned j);
        int unsigned cnt;
        cnt      = 0;
        data_idx = 0;
        for (int unsigned pos = 1; pos < 64; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                if (cnt == j) data_idx = pos - 1;
                cnt++;
            end
        end
    endfunction

    logic              v1, ce1, p1;
    logic [N-1:0]      r1;
    logic [P-1:0]      s1;
    logic              load1, load2, xfer;
    logic [P-1:0]      s_c;
    logic              p_c;
    logic              in_range_c, single_c, double_c;
    logic [N-1:0]      flip_c, word_c;
    logic [DATA_W-1:0] data_c;

    assign load2    = ~out_valid | out_ready;
    assign load1    = ~v1 | load2;
    assign in_ready = load1;
    assign xfer     = out_valid & out_ready;

    // Syndrome and overall parity of the raw codeword.
    always_comb begin
        s_c = '0;
        for (int i = 0; i < N - 1; i++) begin
            if (recibido[i]) s_c = s_c ^ P'(i + 1);
        end
        p_c = ^recibido;
    end

    // Classification and one-hot flip mask from the stage-1 syndrome.
    always_comb begin
        in_range_c = (s1 <= S_MAX);
        single_c   = p1 & in_range_c;
        double_c   = (p1 & ~in_range_c) | (~p1 & (s1 != '0));
        flip_c     = '0;
        for (int i = 0; i < N - 1; i++) begin
            flip_c[i] = (s1 == P'(i + 1));
        end
        // Zero syndrome with odd parity means the overall parity bit itself flipped.
        flip_c[N-1] = (s1 == '0);
        word_c      = r1 ^ (flip_c & {N{single_c & ce1}});
    end

    for (genvar j = 0; j < DATA_W; j++) begin : g_data
        assign data_c[j] = word_c[data_idx(j)];
    end

    // Stage 1: capture raw word, mode, syndrome and parity.
    always_ff @(posedge reloj or negedge rst_n) begin
        if (!rst_n) begin
            v1  <= 1'b0;
            r1  <= '0;
            ce1 <= 1'b0;
            s1  <= '0;
            p1  <= 1'b0;
        end else if (load1) begin
            v1 <= in_valid;
            if (in_valid) begin
                r1  <= recibido;
                ce1 <= corregir_en;
                s1  <= s_c;
                p1  <= p_c;
            end
        end
    end

    // Stage 2: corrected word and flags; holds while the consumer stalls.
    always_ff @(posedge reloj or negedge rst_n) begin
        if (!rst_n) begin
            out_valid         <= 1'b0;
            palabra_corregida <= '0;
            corregido         <= '0;
            sindrome          <= '0;
            error_simple      <= 1'b0;
            error_doble       <= 1'b0;
        end else if (load2) begin
            out_valid <= v1;
            if (v1) begin
                palabra_corregida <= word_c;
                corregido         <= data_c;
                sindrome          <= s1;
                error_simple      <= single_c;
                error_doble       <= double_c;
            end
        end
    end

    // Saturating counters and sticky LED, updated on output transfers.
    always_ff @(posedge reloj or negedge rst_n) begin
        if (!rst_n) begin
            cnt_simple    <= '0;
            cnt_doble     <= '0;
            led_doblerror <= 1'b0;
        end else if (clr_cnt) begin
            cnt_simple    <= '0;
            cnt_doble     <= '0;
            led_doblerror <= 1'b0;
        end else if (xfer) begin
            if (error_simple && (cnt_simple != '1)) cnt_simple <= cnt_simple + CNT_W'(1);
            if (error_doble && (cnt_doble != '1))   cnt_doble  <= cnt_doble + CNT_W'(1);
            if (error_doble)                        led_doblerror <= 1'b1;
        end
    end

endmodule

// File: tb/tb_corrector_secded_param.sv
// Directed bench for corrector_secded_param: a DATA_W=4/CNT_W=2 instance for
// the main checks and a DATA_W=5 instance for the out-of-range syndrome case.
module tb_corrector_secded_param;

    logic       reloj = 1'b0;
    logic       rst_n;
    int         total = 0;
    int         bad   = 0;

    // DATA_W=4 instance (N=8, P=3), CNT_W=2
    logic       in_valid, in_ready, corregir_en, out_valid, out_ready;
    logic [7:0] recibido, palabra;
    logic [3:0] corregido;
    logic [2:0] sindrome;
    logic       es, ed, clr_cnt, led;
    logic [1:0] cnt_s, cnt_d;

    // DATA_W=5 instance (N=10, P=4)
    logic        b_in_valid, b_in_ready, b_ce, b_out_valid;
    logic [9:0]  b_rx, b_word;
    logic [4:0]  b_data;
    logic [3:0]  b_s;
    logic        b_es, b_ed, b_led;
    logic [15:0] b_cnt_s, b_cnt_d;

    always #5 reloj = ~reloj;

    corrector_secded_param #(.DATA_W(4), .CNT_W(2)) u_dut (
        .reloj(reloj), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .recibido(recibido), .corregir_en(corregir_en),
        .out_valid(out_valid), .out_ready(out_ready), .palabra_corregida(palabra),
        .corregido(corregido), .sindrome(sindrome), .error_simple(es), .error_doble(ed),
        .clr_cnt(clr_cnt), .cnt_simple(cnt_s), .cnt_doble(cnt_d), .led_doblerror(led)
    );

    corrector_secded_param #(.DATA_W(5), .CNT_W(16)) u_dut5 (
        .reloj(reloj), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .recibido(b_rx), .corregir_en(b_ce),
        .out_valid(b_out_valid), .out_ready(1'b1), .palabra_corregida(b_word),
        .corregido(b_data), .sindrome(b_s), .error_simple(b_es), .error_doble(b_ed),
        .clr_cnt(1'b0), .cnt_simple(b_cnt_s), .cnt_doble(b_cnt_d), .led_doblerror(b_led)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One word through the DATA_W=4 instance; mode flips after acceptance.
    task automatic run_vec(input string tag, input logic [7:0] w, input logic ce,
                           input logic [7:0] e_word, input logic [3:0] e_data,
                           input logic [2:0] e_s, input logic e_es, input logic e_ed,
                           input logic [1:0] e_cs, input logic [1:0] e_cd, input logic e_led);
        @(negedge reloj);
        in_valid = 1'b1; recibido = w; corregir_en = ce;
        @(negedge reloj);
        in_valid = 1'b0; corregir_en = ~ce;
        check({tag, "_lat"}, 64'(out_valid), 64'd0);
        @(negedge reloj);
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_word"}, 64'(palabra), 64'(e_word));
        check({tag, "_data"}, 64'(corregido), 64'(e_data));
        check({tag, "_synd"}, 64'(sindrome), 64'(e_s));
        check({tag, "_es"}, 64'(es), 64'(e_es));
        check({tag, "_ed"}, 64'(ed), 64'(e_ed));
        @(negedge reloj);
        check({tag, "_cnt_s"}, 64'(cnt_s), 64'(e_cs));
        check({tag, "_cnt_d"}, 64'(cnt_d), 64'(e_cd));
        check({tag, "_led"}, 64'(led), 64'(e_led));
    endtask

    task automatic run_b(input string tag, input logic [9:0] w, input logic ce,
                         input logic [9:0] e_word, input logic [4:0] e_data,
                         input logic [3:0] e_s, input logic e_es, input logic e_ed);
        @(negedge reloj);
        b_in_valid = 1'b1; b_rx = w; b_ce = ce;
        @(negedge reloj);
        b_in_valid = 1'b0;
        @(negedge reloj);
        check({tag, "_valid"}, 64'(b_out_valid), 64'd1);
        check({tag, "_word"}, 64'(b_word), 64'(e_word));
        check({tag, "_data"}, 64'(b_data), 64'(e_data));
        check({tag, "_synd"}, 64'(b_s), 64'(e_s));
        check({tag, "_es"}, 64'(b_es), 64'(e_es));
        check({tag, "_ed"}, 64'(b_ed), 64'(e_ed));
    endtask

    initial begin
        logic [7:0] words [4];
        int sent;
        int got;
        logic fire_in, fire_out;

        rst_n = 1'b0; in_valid = 1'b0; recibido = '0; corregir_en = 1'b1;
        out_ready = 1'b1; clr_cnt = 1'b0;
        b_in_valid = 1'b0; b_rx = '0; b_ce = 1'b1;
        repeat (2) @(negedge reloj);
        check("rst_ovalid", 64'(out_valid), 64'd0);
        check("rst_word", 64'(palabra), 64'd0);
        check("rst_flags", 64'({es, ed, led}), 64'd0);
        check("rst_cnt", 64'({cnt_s, cnt_d}), 64'd0);
        rst_n = 1'b1;
        #1;
        check("rst_iready", 64'(in_ready), 64'd1);

        run_vec("clean",   8'h87, 1'b1, 8'h87, 4'h1, 3'd0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
        run_vec("single",  8'h97, 1'b1, 8'h87, 4'h1, 3'd5, 1'b1, 1'b0, 2'd1, 2'd0, 1'b0);
        run_vec("detect",  8'h97, 1'b0, 8'h97, 4'h3, 3'd5, 1'b1, 1'b0, 2'd2, 2'd0, 1'b0);
        run_vec("parbit",  8'h07, 1'b1, 8'h87, 4'h1, 3'd0, 1'b1, 1'b0, 2'd3, 2'd0, 1'b0);
        run_vec("double",  8'hB7, 1'b1, 8'hB7, 4'h7, 3'd3, 1'b0, 1'b1, 2'd3, 2'd1, 1'b1);

        // DATA_W=5: syndrome 15 > N-1 with odd parity is uncorrectable.
        run_b("b_oor",    10'h08C, 1'b1, 10'h08C, 5'h01, 4'd15, 1'b0, 1'b1);
        run_b("b_pos9",   10'h100, 1'b1, 10'h000, 5'h00, 4'd9,  1'b1, 1'b0);
        run_b("b_pos9_d", 10'h100, 1'b0, 10'h100, 5'h10, 4'd9,  1'b1, 1'b0);

        // Clear, then saturate the 2-bit single-error counter.
        @(negedge reloj); clr_cnt = 1'b1;
        @(negedge reloj); clr_cnt = 1'b0;
        check("clr_cnt_s", 64'(cnt_s), 64'd0);
        check("clr_led", 64'(led), 64'd0);
        for (int i = 0; i < 5; i++) begin
            run_vec("sat", 8'h97, 1'b1, 8'h87, 4'h1, 3'd5, 1'b1, 1'b0,
                    (i >= 2) ? 2'd3 : 2'(i + 1), 2'd0, 1'b0);
        end

        // Clear coinciding with a double-error transfer wins.
        @(negedge reloj); in_valid = 1'b1; recibido = 8'hB7; corregir_en = 1'b1;
        @(negedge reloj); in_valid = 1'b0;
        @(negedge reloj);
        check("clrx_ed", 64'(out_valid & ed), 64'd1);
        clr_cnt = 1'b1;
        @(negedge reloj); clr_cnt = 1'b0;
        check("clrx_cnt_d", 64'(cnt_d), 64'd0);
        check("clrx_led", 64'(led), 64'd0);

        // Backpressure: 4 words, consumer stalled while the first is presented.
        words[0] = 8'h87; words[1] = 8'h97; words[2] = 8'h07; words[3] = 8'hB7;
        sent = 0; got = 0;
        for (int cyc = 0; cyc < 30 && got < 4; cyc++) begin
            @(negedge reloj);
            out_ready   = (cyc >= 5);
            in_valid    = (sent < 4);
            recibido    = words[sent < 4 ? sent : 3];
            corregir_en = 1'b0;
            #1;
            if (cyc >= 2 && cyc <= 4) begin
                check("bp_iready", 64'(in_ready), 64'd0);
                check("bp_hold", 64'({out_valid, palabra}), 64'({1'b1, words[0]}));
            end
            fire_in  = in_valid & in_ready;
            fire_out = out_valid & out_ready;
            if (fire_out) begin
                check("bp_order", 64'(palabra), 64'(words[got]));
                got++;
            end
            if (fire_in) sent++;
        end
        in_valid = 1'b0;
        check("bp_count", 64'(got), 64'd4);
        @(negedge reloj);
        check("bp_nodup", 64'(out_valid), 64'd0);

        // Reset with two words in flight.
        @(negedge reloj);
        out_ready = 1'b0; in_valid = 1'b1; recibido = 8'h97; corregir_en = 1'b1;
        @(negedge reloj); recibido = 8'h07;
        @(negedge reloj); in_valid = 1'b0;
        check("mid_valid", 64'(out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_ovalid", 64'(out_valid), 64'd0);
        check("mid_rst_out", 64'({palabra, corregido, sindrome, es, ed}), 64'd0);
        check("mid_rst_cnt", 64'({cnt_s, cnt_d, led}), 64'd0);
        @(negedge reloj);
        rst_n = 1'b1; out_ready = 1'b1;
        #1;
        check("mid_rst_iready", 64'(in_ready), 64'd1);
        run_vec("post_rst", 8'h97, 1'b1, 8'h87, 4'h1, 3'd5, 1'b1, 1'b0, 2'd1, 2'd0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "timeout");
    end

endmodule
